// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF tone mixer.
//   - key codes for the 16-key keypad (0-9, A-D, '*', '#')
//   - FSM state encodings
//   - key_row / key_col: map a key code onto its keypad row / column index
package dtmf_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TONE = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Row 0: 697 Hz .. row 3: 941 Hz
    function automatic logic [1:0] key_row(input logic [3:0] key);
        logic [1:0] r;
        case (key)
            KEY_1, KEY_2, KEY_3, KEY_A: r = 2'd0;
            KEY_4, KEY_5, KEY_6, KEY_B: r = 2'd1;
            KEY_7, KEY_8, KEY_9, KEY_C: r = 2'd2;
            default:                    r = 2'd3;   // '*', 0, '#', D
        endcase
        return r;
    endfunction

    // Column 0: 1209 Hz .. column 3: 1633 Hz
    function automatic logic [1:0] key_col(input logic [3:0] key);
        logic [1:0] c;
        case (key)
            KEY_1, KEY_4, KEY_7, KEY_STAR: c = 2'd0;
            KEY_2, KEY_5, KEY_8, KEY_0:    c = 2'd1;
            KEY_3, KEY_6, KEY_9, KEY_HASH: c = 2'd2;
            default:                       c = 2'd3;   // A-D
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dtmf_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk_i    : destination clock
//   rst_n_i  : asynchronous active-low reset, clears both stages
//   d_i      : asynchronous inputs
//   q_o      : inputs synchronized to clk_i (two-cycle latency)
module dtmf_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dtmf_tone_mixer.sv
// DTMF tone mixer: accepts one keypad digit per valid/ready handshake and
// gates the matching row/column square-wave pair onto a summed 2-bit output
// for ON_TICKS cycles, followed by OFF_TICKS cycles of silence.
//   inclk        : system clock (1 MHz)
//   rst_n        : asynchronous active-low reset
//   row_tones    : row square waves   [0]=697 [1]=770 [2]=852 [3]=941 Hz
//   col_tones    : column square waves [0]=1209 [1]=1336 [2]=1477 [3]=1633 Hz
//   digit        : key code, sampled on digit_valid & digit_ready
//   digit_valid  : upstream presents a digit
//   digit_ready  : high only while IDLE
//   tone_out     : row_sq + col_sq while sounding, else 0
//   row_sq       : gated selected row tone
//   col_sq       : gated selected column tone
//   busy         : high in TONE or GAP
//
// state | meaning
// IDLE  | waiting for a digit, digit_ready high
// TONE  | selected row/column tones gated to the outputs for ON_TICKS cycles
// GAP   | forced silence for OFF_TICKS cycles
module dtmf_tone_mixer
    import dtmf_pkg::*;
#(
    parameter int ON_TICKS  = 100000,
    parameter int OFF_TICKS = 50000,
    parameter int CNT_W     = 17
) (
    input  logic       inclk,
    input  logic       rst_n,
    input  logic [3:0] row_tones,
    input  logic [3:0] col_tones,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic [1:0] tone_out,
    output logic       row_sq,
    output logic       col_sq,
    output logic       busy
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       digit_q, digit_d;
    logic             ready_q;
    logic             row_q, col_q;
    logic [1:0]       tone_q;

    logic [7:0]       tones_sync;
    logic [3:0]       row_sync, col_sync;
    logic             row_d, col_d;
    logic             accept;

    dtmf_sync2 #(.WIDTH(8)) u_sync (
        .clk_i   (inclk),
        .rst_n_i (rst_n),
        .d_i     ({col_tones, row_tones}),
        .q_o     (tones_sync)
    );

    assign row_sync = tones_sync[3:0];
    assign col_sync = tones_sync[7:4];

    // ready_q is only ever set while IDLE, so it also qualifies the state
    assign accept = digit_valid & ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    digit_d = digit;
                    cnt_d   = '0;
                    state_d = TONE;
                end
            end
            TONE: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign row_d = (state_q == TONE) & row_sync[key_row(digit_q)];
    assign col_d = (state_q == TONE) & col_sync[key_col(digit_q)];

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            digit_q <= '0;
            ready_q <= 1'b0;
            row_q   <= 1'b0;
            col_q   <= 1'b0;
            tone_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            // registered so that ready stays low while reset is asserted
            ready_q <= (state_d == IDLE);
            row_q   <= row_d;
            col_q   <= col_d;
            tone_q  <= {1'b0, row_d} + {1'b0, col_d};
        end
    end

    assign digit_ready = ready_q;
    assign row_sq      = row_q;
    assign col_sq      = col_q;
    assign tone_out    = tone_q;
    assign busy        = (state_q != IDLE);

endmodule
